cordic_rv_pipe: RTL and testbench

CORDIC_RV_PIPE -- requirements
Module: cordic_rv_pipe

---
 rtl/cordic_pkg.sv | 29 ++
 rtl/cordic_stage.sv | 58 +++++
 rtl/cordic_rv_pipe.sv | 142 ++++++++++++++
 tb/tb_cordic_rv_pipe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants for the rotation/vectoring CORDIC pipeline: arctangent
// table, mode encoding, processing gain and quadrant helpers.
package cordic_pkg;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  // Magnitude growth of the full micro-rotation chain.
  localparam real CORDIC_GAIN = 1.6467602581;

  // Angles use full circle = 2^32, so 90 degrees is 2^30.
  localparam logic [31:0] QUAD_90    = 32'h4000_0000;
  localparam logic [1:0]  QUAD_POS90 = 2'b01;
  localparam logic [1:0]  QUAD_NEG90 = 2'b10;

  // Entry i = round(atan(2^-i) * 2^32 / (2*pi)).
  localparam int ATAN_N = 31;
  localparam logic [31:0] ATAN [ATAN_N] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001
  };

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation. The sample's own mode selects
// whether Z (rotation) or Y (vectoring) steers the turn direction.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int SHIFT  = 0,
  parameter int W      = 18,
  parameter int TAG_SZ = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_mode,
  input  logic [TAG_SZ-1:0] in_tag,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  input  logic [31:0]       z_in,
  output logic              out_valid,
  output logic              out_mode,
  output logic [TAG_SZ-1:0] out_tag,
  output logic signed [W-1:0] x_out,
  output logic signed [W-1:0] y_out,
  output logic [31:0]       z_out
);

  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;
  logic                turn_ccw;

  assign x_sh = x_in >>> SHIFT;
  assign y_sh = y_in >>> SHIFT;

  // Counter-clockwise turn: rotation drives Z toward 0 from above,
  // vectoring lifts a negative Y toward 0.
  assign turn_ccw = (in_mode == MODE_ROT) ? ~z_in[31] : y_in[W-1];

  // Valid bit is the only state that must be flushed by reset.
  always_ff @(posedge clock) begin
    if (reset) out_valid <= 1'b0;
    else       out_valid <= in_valid;
  end

  // Payload advances every cycle; bubbles carry don't-care data.
  always_ff @(posedge clock) begin
    out_mode <= in_mode;
    out_tag  <= in_tag;
    if (turn_ccw) begin
      x_out <= x_in - y_sh;
      y_out <= y_in + x_sh;
      z_out <= z_in - ATAN[SHIFT];
    end else begin
      x_out <= x_in + y_sh;
      y_out <= y_in - x_sh;
      z_out <= z_in + ATAN[SHIFT];
    end
  end

endmodule

// File: rtl/cordic_rv_pipe.sv
// Fully pipelined rotation/vectoring CORDIC: input pre-rotation register,
// STG micro-rotation stages and an output register (latency STG+1).
module cordic_rv_pipe
  import cordic_pkg::*;
#(
  parameter int XY_SZ  = 16,
  parameter int STG    = XY_SZ,
  parameter int TAG_SZ = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                in_mode,
  input  logic [TAG_SZ-1:0]   in_tag,
  input  logic [31:0]         angle,
  input  logic [XY_SZ-1:0]    Xin,
  input  logic [XY_SZ-1:0]    Yin,
  output logic                out_valid,
  output logic                out_mode,
  output logic [TAG_SZ-1:0]   out_tag,
  output logic [XY_SZ+1:0]    Xout,
  output logic [XY_SZ+1:0]    Yout,
  output logic [31:0]         Zout
);

  // Two guard bits: one for negating -2^(XY_SZ-1), one for the gain.
  localparam int W = XY_SZ + 2;

  logic signed [W-1:0] xe, ye, x_pre, y_pre;
  logic [31:0]         z_pre;

  logic                v0, m0;
  logic [TAG_SZ-1:0]   t0;
  logic signed [W-1:0] x0, y0;
  logic [31:0]         z0;

  logic                v_s [0:STG];
  logic                m_s [0:STG];
  logic [TAG_SZ-1:0]   t_s [0:STG];
  logic signed [W-1:0] x_s [0:STG];
  logic signed [W-1:0] y_s [0:STG];
  logic [31:0]         z_s [0:STG];

  // Pre-rotate by +/-90 degrees so the micro-rotations only cover +/-99.9.
  always_comb begin
    xe    = {{2{Xin[XY_SZ-1]}}, Xin};
    ye    = {{2{Yin[XY_SZ-1]}}, Yin};
    x_pre = xe;
    y_pre = ye;
    z_pre = angle;
    if (in_mode == MODE_ROT) begin
      case (angle[31:30])
        QUAD_POS90: begin
          x_pre = -ye;
          y_pre = xe;
          z_pre = angle - QUAD_90;
        end
        QUAD_NEG90: begin
          x_pre = ye;
          y_pre = -xe;
          z_pre = angle + QUAD_90;
        end
        default: ;
      endcase
    end else if (Xin[XY_SZ-1]) begin
      if (!Yin[XY_SZ-1]) begin
        x_pre = ye;
        y_pre = -xe;
        z_pre = angle + QUAD_90;
      end else begin
        x_pre = -ye;
        y_pre = xe;
        z_pre = angle - QUAD_90;
      end
    end
  end

  // Entry valid; in_valid is ignored while reset is high.
  always_ff @(posedge clock) begin
    if (reset) v0 <= 1'b0;
    else       v0 <= in_valid;
  end

  // Entry payload register.
  always_ff @(posedge clock) begin
    m0 <= in_mode;
    t0 <= in_tag;
    x0 <= x_pre;
    y0 <= y_pre;
    z0 <= z_pre;
  end

  assign v_s[0] = v0;
  assign m_s[0] = m0;
  assign t_s[0] = t0;
  assign x_s[0] = x0;
  assign y_s[0] = y0;
  assign z_s[0] = z0;

  for (genvar i = 0; i < STG; i++) begin : g_stage
    cordic_stage #(
      .SHIFT  (i),
      .W      (W),
      .TAG_SZ (TAG_SZ)
    ) u_stage (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (v_s[i]),
      .in_mode   (m_s[i]),
      .in_tag    (t_s[i]),
      .x_in      (x_s[i]),
      .y_in      (y_s[i]),
      .z_in      (z_s[i]),
      .out_valid (v_s[i+1]),
      .out_mode  (m_s[i+1]),
      .out_tag   (t_s[i+1]),
      .x_out     (x_s[i+1]),
      .y_out     (y_s[i+1]),
      .z_out     (z_s[i+1])
    );
  end

  // Output register, fully cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_tag   <= '0;
      Xout      <= '0;
      Yout      <= '0;
      Zout      <= '0;
    end else begin
      out_valid <= v_s[STG];
      out_mode  <= m_s[STG];
      out_tag   <= t_s[STG];
      Xout      <= x_s[STG];
      Yout      <= y_s[STG];
      Zout      <= z_s[STG];
    end
  end

endmodule

// File: tb/tb_cordic_rv_pipe.sv
// Directed scoreboard bench for cordic_rv_pipe (XY_SZ=16, STG=16).
module tb_cordic_rv_pipe;

  localparam int XY  = 16;
  localparam int NST = 16;
  localparam int LAT = NST + 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_mode = 1'b0;
  logic [3:0]  in_tag = '0;
  logic [31:0] angle = '0;
  logic [15:0] Xin = '0;
  logic [15:0] Yin = '0;
  logic        out_valid, out_mode;
  logic [3:0]  out_tag;
  logic [17:0] Xout, Yout;
  logic [31:0] Zout;

  cordic_rv_pipe #(.XY_SZ(XY), .STG(NST), .TAG_SZ(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_mode(in_mode),
    .in_tag(in_tag), .angle(angle), .Xin(Xin), .Yin(Yin),
    .out_valid(out_valid), .out_mode(out_mode), .out_tag(out_tag),
    .Xout(Xout), .Yout(Yout), .Zout(Zout)
  );

  always #5 clock = ~clock;

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt++;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit        mode;
    bit [3:0]  tag;
    int        sedge;
    int        mx, my;
    bit [31:0] mz;
    bit        ideal;
    int        ix, iy;
    bit [31:0] iz;
    string     name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int unsigned atan_tab [0:30];

  task automatic chk_eq(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_tol(input string tag, input longint obs, input longint expv, input longint tol);
    checks++;
    assert ((((obs - expv) <= tol) && ((expv - obs) <= tol)) === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, expv, tol);
    end
  endtask

  // Bit-true reference of the algorithm: pre-rotation then NST micro-rotations.
  function automatic void model(input bit mode, input int xin, input int yin,
                                input bit [31:0] ang, output int xo, output int yo,
                                output bit [31:0] zo);
    int x, y, xt;
    bit [31:0] z;
    bit [1:0] q;
    x = xin; y = yin; z = ang; q = ang[31:30];
    if (mode == 1'b0) begin
      if (q == 2'b01) begin x = -yin; y = xin; z = ang - 32'h4000_0000; end
      else if (q == 2'b10) begin x = yin; y = -xin; z = ang + 32'h4000_0000; end
    end else if (xin < 0) begin
      if (yin >= 0) begin x = yin; y = -xin; z = ang + 32'h4000_0000; end
      else begin x = -yin; y = xin; z = ang - 32'h4000_0000; end
    end
    for (int i = 0; i < NST; i++) begin
      if (mode == 1'b0) begin
        if (z[31] == 1'b0) begin xt = x - (y >>> i); y = y + (x >>> i); z = z - atan_tab[i]; end
        else begin xt = x + (y >>> i); y = y - (x >>> i); z = z + atan_tab[i]; end
      end else begin
        if (y >= 0) begin xt = x + (y >>> i); y = y - (x >>> i); z = z + atan_tab[i]; end
        else begin xt = x - (y >>> i); y = y + (x >>> i); z = z - atan_tab[i]; end
      end
      x = xt;
    end
    xo = x; yo = y; zo = z;
  endfunction

  task automatic drive(input bit v, input bit mode, input bit [3:0] tag,
                       input int x, input int y, input bit [31:0] ang,
                       input bit ideal, input int ix, input int iy,
                       input bit [31:0] iz, input string name);
    exp_t e;
    @(negedge clock);
    in_valid = v; in_mode = mode; in_tag = tag; angle = ang;
    Xin = x[15:0]; Yin = y[15:0];
    if (v && !reset) begin
      e.mode = mode; e.tag = tag; e.sedge = edge_cnt + 1;
      model(mode, x, y, ang, e.mx, e.my, e.mz);
      e.ideal = ideal; e.ix = ix; e.iy = iy; e.iz = iz; e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 4'h0, 0, 0, 32'h0, 1'b0, 0, 0, 32'h0, "bubble");
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
    chk_eq("drain_empty", sb.size(), 0);
  endtask

  // Scoreboard monitor: compares each emerging result with the oldest expectation.
  always @(negedge clock) begin
    if (out_valid === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_output observed=valid expected=none tag=%0d", out_tag);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk_eq({mon_e.name, "_latency"}, edge_cnt - mon_e.sedge, LAT);
        chk_eq({mon_e.name, "_tag"}, out_tag, mon_e.tag);
        chk_eq({mon_e.name, "_mode"}, out_mode, mon_e.mode);
        chk_eq({mon_e.name, "_x"}, $signed(Xout), mon_e.mx);
        chk_eq({mon_e.name, "_y"}, $signed(Yout), mon_e.my);
        chk_eq({mon_e.name, "_z"}, Zout, mon_e.mz);
        if (mon_e.ideal) begin
          chk_tol({mon_e.name, "_x_ideal"}, $signed(Xout), mon_e.ix, 4);
          chk_tol({mon_e.name, "_y_ideal"}, $signed(Yout), mon_e.iy, 4);
          chk_tol({mon_e.name, "_z_ideal_diff"}, $signed(Zout - mon_e.iz), 0, 262144);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int r_edge;
    int xs, ys;
    for (int i = 0; i <= 30; i++)
      atan_tab[i] = $rtoi($atan(2.0 ** (-i)) * 4294967296.0 / (2.0 * 3.141592653589793) + 0.5);

    // Reset held with in_valid high: inputs ignored, outputs cleared.
    reset = 1'b1;
    in_valid = 1'b1; Xin = 16'd1234; Yin = 16'd99; angle = 32'h1234_5678; in_tag = 4'hA;
    repeat (3) @(negedge clock);
    chk_eq("rst_valid", out_valid, 0);
    chk_eq("rst_x", Xout, 0);
    chk_eq("rst_y", Yout, 0);
    chk_eq("rst_z", Zout, 0);
    chk_eq("rst_tag", out_tag, 0);
    chk_eq("rst_mode", out_mode, 0);
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (20) @(negedge clock);
    chk_eq("idle_after_rst", out_valid, 0);

    // Directed cases with closed-form expectations.
    drive(1, 0, 4'h1, 10000, 0, 32'h2000_0000, 1, 11645, 11645, 32'h0, "rot45");
    repeat (3) bubble();
    drive(1, 0, 4'h2, 10000, 0, 32'h4000_0000, 1, 0, 16468, 32'h0, "rot90");
    drive(1, 1, 4'h3, -10000, 10000, 32'h0, 1, 23290, 0, 32'h6000_0000, "vec135");
    bubble();
    drive(1, 1, 4'h4, -32768, -32768, 32'h0, 1, 76315, 0, 32'hA000_0000, "vec_extreme");
    drive(1, 0, 4'h5, 20000, -5000, 32'hB000_0000, 0, 0, 0, 32'h0, "rot_q10");
    bubble();
    drain();

    // Back-to-back stream, alternating modes, wrapping tags.
    for (int k = 0; k < 20; k++) begin
      xs = int'($urandom_range(0, 65535)) - 32768;
      ys = int'($urandom_range(0, 65535)) - 32768;
      drive(1, k[0], k[3:0], xs, ys, $urandom, 0, 0, 0, 32'h0, $sformatf("stream%0d", k));
    end
    bubble();
    drain();

    // One-cycle reset on the 5th clock of a stream.
    for (int k = 0; k < 4; k++)
      drive(1, k[0], k[3:0], 3000 * (k + 1), -1000 * k, 32'h1000_0000 * k, 0, 0, 0, 32'h0, "pre_rst");
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b1;
    sb.delete();
    r_edge = edge_cnt + 1;
    @(negedge clock);
    reset = 1'b0;
    chk_eq("rst_edge", edge_cnt, r_edge);
    for (int k = 0; k < 17; k++) begin
      if (k == 0) begin
        in_valid = 1'b1; in_mode = 1'b0; in_tag = 4'hC; Xin = 16'd8000; Yin = 16'd2000;
        angle = 32'hE000_0000;
        mon_e.mode = 1'b0; mon_e.tag = 4'hC; mon_e.sedge = edge_cnt + 1;
        model(1'b0, 8000, 2000, 32'hE000_0000, mon_e.mx, mon_e.my, mon_e.mz);
        mon_e.ideal = 1'b0; mon_e.name = "post_rst0";
        sb.push_back(mon_e);
      end else if (k < 6) begin
        drive(1, k[0], 4'hC + k[3:0], 1500 * k, 7000 - 2000 * k, 32'h3000_0000 * k, 0, 0, 0, 32'h0, "post_rst");
      end else begin
        bubble();
      end
      chk_eq("quiet_after_rst", out_valid, 0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
